// File: rtl/counter_pkg.sv
// Shared constants and helpers for the up/down modulo counter family.
package counter_pkg;

  // Boundary behaviour selectors for the SATURATE parameter.
  localparam int unsigned CNT_WRAP = 0;
  localparam int unsigned CNT_SAT  = 1;

  // Width of the prescaler phase register; never below one bit.
  function automatic int unsigned presc_width(input int unsigned prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

endpackage

// File: rtl/counter_updn_mod_if.sv
// Control/status bundle between a counter user (master) and the counter (slave).
interface counter_updn_mod_if #(
  parameter int unsigned WIDTH = 8
);

  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             ovf;

  modport master (
    output en, up_dn, load, load_val,
    input  count, tc, ovf
  );

  modport slave (
    input  en, up_dn, load, load_val,
    output count, tc, ovf
  );

endinterface

// File: rtl/counter_updn_mod_prescaler.sv
// Step qualifier: pulses tick on every PRESCALE-th enabled cycle.
module counter_prescaler
  import counter_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  generate
    if (PRESCALE == 1) begin : g_bypass
      // Every enabled cycle is a step; no phase state is kept.
      logic unused_ok;
      assign unused_ok = &{1'b0, clk, reset, clr};
      assign tick      = en;
    end else begin : g_div
      localparam int unsigned PW = presc_width(PRESCALE);
      localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

      logic [PW-1:0] pre_q;
      logic [PW-1:0] pre_d;

      // Phase advance: clear wins, otherwise roll over at LAST while enabled.
      always_comb begin
        pre_d = pre_q;
        if (clr) begin
          pre_d = '0;
        end else if (en) begin
          pre_d = (pre_q == LAST) ? '0 : pre_q + PW'(1);
        end
      end

      // Phase register.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          pre_q <= '0;
        end else begin
          pre_q <= pre_d;
        end
      end

      assign tick = en && !clr && (pre_q == LAST);
    end
  endgenerate

endmodule

// File: rtl/counter_updn_mod.sv
// Up/down modulo counter with load, prescaled enable, wrap/saturate and flags.
module counter_updn_mod
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_VAL  = 2**WIDTH - 1,
  parameter int unsigned SATURATE = CNT_WRAP,
  parameter int unsigned PRESCALE = 1
) (
  input  logic                clk,
  input  logic                reset,
  counter_updn_mod_if.slave   bus
);

  localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX_VAL);
  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH + 1)'(MAX_VAL);
  localparam bit               SAT     = (SATURATE == CNT_SAT);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             ovf_q;
  logic             ovf_d;
  logic             tick;
  logic [WIDTH:0]   lv_ext;

  counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (bus.en),
    .clr   (bus.load),
    .tick  (tick)
  );

  // Zero-extended so the clamp compare stays meaningful when MAX_VAL is all ones.
  assign lv_ext = {1'b0, bus.load_val};

  // Next count: load (clamped) beats step; boundary checked before the add.
  always_comb begin
    count_d = count_q;
    ovf_d   = 1'b0;
    if (bus.load) begin
      count_d = (lv_ext > MAX_EXT) ? MAX_V : bus.load_val;
    end else if (tick) begin
      if (bus.up_dn) begin
        if (count_q == MAX_V) begin
          ovf_d   = 1'b1;
          count_d = SAT ? count_q : '0;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (count_q == '0) begin
          ovf_d   = 1'b1;
          count_d = SAT ? count_q : MAX_V;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  // Count and overflow-pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.count = count_q;
  assign bus.ovf   = ovf_q;
  assign bus.tc    = bus.up_dn ? (count_q == MAX_V) : (count_q == '0);

endmodule

// File: tb/tb_counter_updn_mod.sv
// Bench for counter_updn_mod across four configurations sharing one stimulus.
//   0: WIDTH=3 defaults   1: WIDTH=4 MAX 9 wrap
//   2: WIDTH=4 MAX 9 sat  3: WIDTH=4 MAX 9 wrap PRESCALE=4
module tb_counter_updn_mod;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up_dn;
  logic       load;
  logic [3:0] load_val;

  int n_tests;
  int n_fail;

  // Reference state per configuration.
  int m_cnt [4];
  int m_pre [4];
  int m_ovf [4];

  logic [3:0] d_cnt [4];
  logic       d_tc  [4];
  logic       d_ovf [4];

  counter_updn_mod_if #(.WIDTH(3)) if_a ();
  counter_updn_mod_if #(.WIDTH(4)) if_b ();
  counter_updn_mod_if #(.WIDTH(4)) if_c ();
  counter_updn_mod_if #(.WIDTH(4)) if_d ();

  assign if_a.en = en;  assign if_a.up_dn = up_dn;  assign if_a.load = load;
  assign if_b.en = en;  assign if_b.up_dn = up_dn;  assign if_b.load = load;
  assign if_c.en = en;  assign if_c.up_dn = up_dn;  assign if_c.load = load;
  assign if_d.en = en;  assign if_d.up_dn = up_dn;  assign if_d.load = load;
  assign if_a.load_val = load_val[2:0];
  assign if_b.load_val = load_val;
  assign if_c.load_val = load_val;
  assign if_d.load_val = load_val;

  assign d_cnt[0] = {1'b0, if_a.count};
  assign d_cnt[1] = if_b.count;
  assign d_cnt[2] = if_c.count;
  assign d_cnt[3] = if_d.count;
  assign d_tc[0]  = if_a.tc;   assign d_ovf[0] = if_a.ovf;
  assign d_tc[1]  = if_b.tc;   assign d_ovf[1] = if_b.ovf;
  assign d_tc[2]  = if_c.tc;   assign d_ovf[2] = if_c.ovf;
  assign d_tc[3]  = if_d.tc;   assign d_ovf[3] = if_d.ovf;

  counter_updn_mod #(.WIDTH(3)) u_a (.clk(clk), .reset(rst), .bus(if_a));
  counter_updn_mod #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0), .PRESCALE(1))
    u_b (.clk(clk), .reset(rst), .bus(if_b));
  counter_updn_mod #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1), .PRESCALE(1))
    u_c (.clk(clk), .reset(rst), .bus(if_c));
  counter_updn_mod #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0), .PRESCALE(4))
    u_d (.clk(clk), .reset(rst), .bus(if_d));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int cfg_max(input int i);
    return (i == 0) ? 7 : 9;
  endfunction

  function automatic int cfg_sat(input int i);
    return (i == 2) ? 1 : 0;
  endfunction

  function automatic int cfg_pre(input int i);
    return (i == 3) ? 4 : 1;
  endfunction

  function automatic int model_tc(input int i);
    return up_dn ? int'(m_cnt[i] == cfg_max(i)) : int'(m_cnt[i] == 0);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_cnt[i] = 0;
      m_pre[i] = 0;
      m_ovf[i] = 0;
    end
  endtask

  // Behaviour at one rising edge, from the counting rules (modular arithmetic).
  task automatic model_edge();
    for (int i = 0; i < 4; i++) begin
      int lv;
      int mx;
      mx = cfg_max(i);
      lv = (i == 0) ? int'(load_val) % 8 : int'(load_val);
      if (load) begin
        m_cnt[i] = (lv > mx) ? mx : lv;
        m_pre[i] = 0;
        m_ovf[i] = 0;
      end else if (!en) begin
        m_ovf[i] = 0;
      end else if (m_pre[i] + 1 < cfg_pre(i)) begin
        m_pre[i] = m_pre[i] + 1;
        m_ovf[i] = 0;
      end else begin
        m_pre[i] = 0;
        if (up_dn) begin
          m_ovf[i] = int'(m_cnt[i] == mx);
          if (!(m_ovf[i] != 0 && cfg_sat(i) != 0)) m_cnt[i] = (m_cnt[i] + 1) % (mx + 1);
        end else begin
          m_ovf[i] = int'(m_cnt[i] == 0);
          if (!(m_ovf[i] != 0 && cfg_sat(i) != 0)) m_cnt[i] = (m_cnt[i] + mx) % (mx + 1);
        end
      end
    end
  endtask

  // One clock: reference follows the edge, return at the falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #3;
    model_clear();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    up_dn = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (d_cnt[i] !== 4'd0) begin
        n_fail++;
        $display("FAIL reset_count dut%0d: got %0d expected 0", i, d_cnt[i]);
      end
      n_tests++;
      if (d_ovf[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_ovf dut%0d: got %b expected 0", i, d_ovf[i]);
      end
      n_tests++;
      if (d_tc[i] !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_tc_down dut%0d: got %b expected 1", i, d_tc[i]);
      end
    end
    up_dn = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (d_tc[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_tc_up dut%0d: got %b expected 0", i, d_tc[i]);
      end
    end
    @(negedge clk);
    model_clear();
    rst = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    en = 1'b1; up_dn = 1'b1; load = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      n_tests++;
      if (d_cnt[0] !== 4'(k % 8) || d_ovf[0] !== (k == 8)) begin
        n_fail++;
        $display("FAIL wrap_w3 step%0d: got cnt=%0d ovf=%b expected cnt=%0d ovf=%b",
                 k, d_cnt[0], d_ovf[0], k % 8, (k == 8));
      end
    end
    // Asynchronous reset between edges clears the count before the next edge.
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    model_clear();
    n_tests++;
    if (d_cnt[0] !== 4'd0 || d_cnt[1] !== 4'd0) begin
      n_fail++;
      $display("FAIL async_reset_count: got a=%0d b=%0d expected 0", d_cnt[0], d_cnt[1]);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_mod10();
    do_reset();
    en = 1'b1; up_dn = 1'b1; load = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      n_tests++;
      if (d_cnt[1] !== 4'(k % 10) || d_ovf[1] !== (k == 10) || d_tc[1] !== (k == 9)) begin
        n_fail++;
        $display("FAIL mod10_up step%0d: got cnt=%0d ovf=%b tc=%b expected cnt=%0d ovf=%b tc=%b",
                 k, d_cnt[1], d_ovf[1], d_tc[1], k % 10, (k == 10), (k == 9));
      end
    end
    up_dn = 1'b0;
    #1;
    n_tests++;
    if (d_tc[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL mod10_tc_down: got %b expected 1", d_tc[1]);
    end
    tick();
    n_tests++;
    if (d_cnt[1] !== 4'd9 || d_ovf[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL mod10_underflow: got cnt=%0d ovf=%b expected cnt=9 ovf=1", d_cnt[1], d_ovf[1]);
    end
    tick();
    n_tests++;
    if (d_cnt[1] !== 4'd8 || d_ovf[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL mod10_down: got cnt=%0d ovf=%b expected cnt=8 ovf=0", d_cnt[1], d_ovf[1]);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    en = 1'b1; up_dn = 1'b1; load = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      n_tests++;
      if (d_cnt[2] !== 4'((k > 9) ? 9 : k) || d_ovf[2] !== (k >= 10)) begin
        n_fail++;
        $display("FAIL sat_up step%0d: got cnt=%0d ovf=%b expected cnt=%0d ovf=%b",
                 k, d_cnt[2], d_ovf[2], (k > 9) ? 9 : k, (k >= 10));
      end
    end
    do_reset();
    up_dn = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      tick();
      n_tests++;
      if (d_cnt[2] !== 4'd0 || d_ovf[2] !== 1'b1) begin
        n_fail++;
        $display("FAIL sat_down step%0d: got cnt=%0d ovf=%b expected cnt=0 ovf=1",
                 k, d_cnt[2], d_ovf[2]);
      end
    end
  endtask

  task automatic test_load();
    do_reset();
    en = 1'b1; up_dn = 1'b1; load = 1'b1; load_val = 4'd5;
    tick();
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (d_cnt[i] !== 4'd5 || d_ovf[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL load5 dut%0d: got cnt=%0d ovf=%b expected cnt=5 ovf=0", i, d_cnt[i], d_ovf[i]);
      end
    end
    load_val = 4'd12;
    tick();
    for (int i = 1; i < 4; i++) begin
      n_tests++;
      if (d_cnt[i] !== 4'd9) begin
        n_fail++;
        $display("FAIL load_clamp dut%0d: got %0d expected 9", i, d_cnt[i]);
      end
    end
    load = 1'b0;
  endtask

  task automatic test_prescale();
    int exp_seq [10];
    do_reset();
    en = 1'b1; up_dn = 1'b1; load = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_tests++;
      if (d_cnt[3] !== 4'(k / 4)) begin
        n_fail++;
        $display("FAIL presc_run cyc%0d: got %0d expected %0d", k, d_cnt[3], k / 4);
      end
    end
    // Two more enabled cycles, three idle, two enabled: twelve enabled in all.
    exp_seq = '{2, 2, 2, 2, 2, 2, 3, 3, 3, 3};
    for (int k = 0; k < 7; k++) begin
      en = !(k >= 2 && k <= 4);
      tick();
      n_tests++;
      if (d_cnt[3] !== 4'(exp_seq[k])) begin
        n_fail++;
        $display("FAIL presc_gap cyc%0d: got %0d expected %0d", k, d_cnt[3], exp_seq[k]);
      end
    end
    en = 1'b1;
    tick();
    load = 1'b1; load_val = 4'd0;
    tick();
    load = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_tests++;
      if (d_cnt[3] !== 4'((k == 4) ? 1 : 0)) begin
        n_fail++;
        $display("FAIL presc_after_load cyc%0d: got %0d expected %0d", k, d_cnt[3], (k == 4) ? 1 : 0);
      end
    end
  endtask

  task automatic test_async_ovf();
    do_reset();
    en = 1'b1; up_dn = 1'b1; load = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    n_tests++;
    if (d_ovf[2] !== 1'b1 || d_cnt[2] !== 4'd9) begin
      n_fail++;
      $display("FAIL async_ovf_pre: got cnt=%0d ovf=%b expected cnt=9 ovf=1", d_cnt[2], d_ovf[2]);
    end
    #2;
    rst = 1'b1;
    #1;
    model_clear();
    n_tests++;
    if (d_ovf[2] !== 1'b0 || d_cnt[2] !== 4'd0) begin
      n_fail++;
      $display("FAIL async_ovf_clear: got cnt=%0d ovf=%b expected cnt=0 ovf=0", d_cnt[2], d_ovf[2]);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      en       = ($urandom_range(0, 3) != 0);
      up_dn    = ($urandom_range(0, 2) != 0);
      load     = ($urandom_range(0, 11) == 0);
      load_val = 4'($urandom_range(0, 15));
      #1;
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (d_tc[i] !== 1'(model_tc(i))) begin
          n_fail++;
          $display("FAIL rand_tc cyc%0d dut%0d: got %b expected %0d", c, i, d_tc[i], model_tc(i));
        end
      end
      tick();
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (d_cnt[i] !== 4'(m_cnt[i]) || d_ovf[i] !== 1'(m_ovf[i])) begin
          n_fail++;
          $display("FAIL rand_step cyc%0d dut%0d: got cnt=%0d ovf=%b expected cnt=%0d ovf=%0d",
                   c, i, d_cnt[i], d_ovf[i], m_cnt[i], m_ovf[i]);
        end
      end
    end
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst      = 1'b1;
    en       = 1'b0;
    up_dn    = 1'b1;
    load     = 1'b0;
    load_val = 4'd0;
    model_clear();
    test_reset();
    test_wrap();
    test_mod10();
    test_saturate();
    test_load();
    test_prescale();
    test_async_ovf();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
